// File: rtl/imm_ext_pkg.sv
// Shared definitions for immediate extension.
// Provides the 2-bit extension-mode type and its encodings, used by the
// combinational extender and by any decode logic that selects a mode.
package imm_ext_pkg;

   typedef logic [1:0] imm_mode_t;

   localparam imm_mode_t IMM_SIGN   = 2'b00;  // replicate imm MSB
   localparam imm_mode_t IMM_ZERO   = 2'b01;  // zero-fill upper bits
   localparam imm_mode_t IMM_UPPER  = 2'b10;  // imm in top bits, zero-fill low bits (LUI)
   localparam imm_mode_t IMM_BRANCH = 2'b11;  // sign-extended word offset, scaled by 4

endpackage : imm_ext_pkg

// File: rtl/imm_ext_core.sv
// Pure combinational IN_W -> OUT_W immediate extender.
// Ports:
//   imm_i   [IN_W-1:0]  raw immediate field
//   mode_i  [1:0]       extension mode (imm_ext_pkg encodings)
//   data_o  [OUT_W-1:0] extended result
module imm_ext_core
   import imm_ext_pkg::*;
#(
   parameter int unsigned IN_W  = 16,
   parameter int unsigned OUT_W = 32
) (
   input  logic [IN_W-1:0]  imm_i,
   input  imm_mode_t        mode_i,
   output logic [OUT_W-1:0] data_o
);

   localparam int unsigned E = OUT_W - IN_W;

   if (IN_W < 2) begin : g_bad_in_w
      $error("imm_ext_core: IN_W must be >= 2");
   end
   if (OUT_W < IN_W + 2) begin : g_bad_out_w
      $error("imm_ext_core: OUT_W must be >= IN_W+2");
   end

   logic [OUT_W-1:0] sign_ext;
   logic [OUT_W-1:0] zero_ext;
   logic [OUT_W-1:0] upper_ext;
   logic [OUT_W-1:0] branch_ext;

   assign sign_ext   = {{E{imm_i[IN_W-1]}}, imm_i};
   assign zero_ext   = {{E{1'b0}}, imm_i};
   // {imm, E zeros} is exactly IN_W+E = OUT_W bits wide, so no truncation is needed.
   assign upper_ext  = {imm_i, {E{1'b0}}};
   // Shift drops the top two sign copies; E >= 2 guarantees no value bits are lost.
   assign branch_ext = sign_ext << 2;

   always_comb begin
      data_o = sign_ext;
      unique case (mode_i)
         IMM_SIGN:   data_o = sign_ext;
         IMM_ZERO:   data_o = zero_ext;
         IMM_UPPER:  data_o = upper_ext;
         IMM_BRANCH: data_o = branch_ext;
         default:    data_o = sign_ext;
      endcase
   end

endmodule : imm_ext_core

// File: rtl/imm_extend_stage.sv
// Registered immediate-generation stage for the ID->EX path.
// One pipeline register with valid/ready handshake, stall back-pressure and
// flush; a side-band tag travels alongside the extended immediate.
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   in_valid/in_ready           input handshake (in_ready is combinational)
//   in_imm, in_mode, in_tag     raw immediate, extension mode, side-band tag
//   flush                       discard held beat and block the incoming one
//   out_valid/out_ready         output handshake
//   out_data, out_tag           registered extended immediate and its tag
module imm_extend_stage
   import imm_ext_pkg::*;
#(
   parameter int unsigned IN_W  = 16,
   parameter int unsigned OUT_W = 32,
   parameter int unsigned TAG_W = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_imm,
   input  imm_mode_t        in_mode,
   input  logic [TAG_W-1:0] in_tag,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data,
   output logic [TAG_W-1:0] out_tag
);

   logic [OUT_W-1:0] ext_data;
   logic             load;

   logic             valid_q, valid_d;
   logic [OUT_W-1:0] data_q,  data_d;
   logic [TAG_W-1:0] tag_q,   tag_d;

   imm_ext_core #(
      .IN_W  (IN_W),
      .OUT_W (OUT_W)
   ) u_core (
      .imm_i  (in_imm),
      .mode_i (in_mode),
      .data_o (ext_data)
   );

   // Accept when the register is empty or being drained this cycle; flush blocks intake.
   assign in_ready = !flush && (!valid_q || out_ready);
   assign load     = in_valid && in_ready;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      tag_d   = tag_q;
      if (flush) begin
         valid_d = 1'b0;
      end else if (load) begin
         valid_d = 1'b1;
         data_d  = ext_data;
         tag_d   = in_tag;
      end else if (valid_q && out_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         tag_q   <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         tag_q   <= tag_d;
      end
   end

   assign out_valid = valid_q;
   assign out_data  = data_q;
   assign out_tag   = tag_q;

endmodule : imm_extend_stage

// File: tb/tb_imm_extend_stage.sv
module tb_imm_extend_stage;
   import imm_ext_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_imm;
   imm_mode_t   in_mode;
   logic [4:0]  in_tag;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [4:0]  out_tag;

   int checks = 0;
   int errors = 0;

   logic [36:0] exp_q[$];  // {data, tag}

   imm_extend_stage #(
      .IN_W  (16),
      .OUT_W (32),
      .TAG_W (5)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_imm    (in_imm),
      .in_mode   (in_mode),
      .in_tag    (in_tag),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_tag   (out_tag)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every completed output transfer is matched against the scoreboard.
   always @(negedge clk) begin
      if (!reset && !flush && out_valid === 1'b1 && out_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: got data %h tag %h expected none", out_data, out_tag);
         end else begin
            logic [36:0] e;
            e = exp_q.pop_front();
            check("beat_data", out_data, e[36:5]);
            check("beat_tag", {27'd0, out_tag}, {27'd0, e[4:0]});
         end
      end
   end

   // Called just after a rising edge; returns just after the edge that accepted the beat.
   task automatic send(input logic [15:0] imm, input imm_mode_t mode, input logic [4:0] tag,
                       input logic [31:0] exp);
      int n;
      in_valid = 1'b1;
      in_imm   = imm;
      in_mode  = mode;
      in_tag   = tag;
      n = 0;
      @(negedge clk);
      while (in_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (in_ready !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: got in_ready %b expected 1", in_ready);
      end else begin
         exp_q.push_back({exp, tag});
         @(posedge clk);
         #1;
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [15:0] s_imm [8] = '{16'h0001, 16'h8000, 16'h8000, 16'h1234,
                              16'h0001, 16'h8000, 16'hFFFF, 16'h7FFF};
   imm_mode_t   s_mode[8] = '{IMM_SIGN, IMM_SIGN, IMM_ZERO, IMM_UPPER,
                              IMM_BRANCH, IMM_BRANCH, IMM_UPPER, IMM_SIGN};
   logic [31:0] s_exp [8] = '{32'h00000001, 32'hFFFF8000, 32'h00008000, 32'h12340000,
                              32'h00000004, 32'hFFFE0000, 32'hFFFF0000, 32'h00007FFF};

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset     = 1'b1;
      flush     = 1'b0;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_imm    = 16'h8001;
      in_mode   = IMM_SIGN;
      in_tag    = 5'd9;
      step();
      step();
      check("reset_valid", {31'd0, out_valid}, 32'd0);
      check("reset_data", out_data, 32'd0);
      check("reset_tag", {27'd0, out_tag}, 32'd0);
      reset = 1'b0;

      // Mode coverage; first beat also checks 1-cycle latency after reset
      send(16'h8001, IMM_SIGN, 5'd9, 32'hFFFF8001);
      check("latency_valid", {31'd0, out_valid}, 32'd1);
      send(16'h8001, IMM_ZERO, 5'd9, 32'h00008001);
      send(16'h8001, IMM_UPPER, 5'd9, 32'h80010000);
      send(16'hFFFF, IMM_BRANCH, 5'd9, 32'hFFFFFFFC);
      send(16'h7FFF, IMM_BRANCH, 5'd9, 32'h0001FFFC);
      in_valid = 1'b0;
      step();

      // Back-pressure
      out_ready = 1'b0;
      send(16'h0010, IMM_ZERO, 5'd3, 32'h00000010);
      in_valid = 1'b1;
      in_imm   = 16'h0020;
      in_mode  = IMM_ZERO;
      in_tag   = 5'd4;
      for (int i = 0; i < 3; i++) begin
         check("stall_in_ready", {31'd0, in_ready}, 32'd0);
         check("stall_valid", {31'd0, out_valid}, 32'd1);
         check("stall_data", out_data, 32'h00000010);
         step();
      end
      out_ready = 1'b1;
      send(16'h0020, IMM_ZERO, 5'd4, 32'h00000020);
      check("nobubble_valid", {31'd0, out_valid}, 32'd1);
      check("nobubble_data", out_data, 32'h00000020);
      in_valid = 1'b0;
      step();

      // Streaming
      for (int i = 0; i < 8; i++) begin
         send(s_imm[i], s_mode[i], 5'(i + 1), s_exp[i]);
         check("stream_valid", {31'd0, out_valid}, 32'd1);
      end
      in_valid = 1'b0;
      step();
      check("drain_valid", {31'd0, out_valid}, 32'd0);

      // Flush with held beat and an incoming beat
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_imm    = 16'h00AA;
      in_mode   = IMM_ZERO;
      in_tag    = 5'd7;
      step();
      check("hold_valid", {31'd0, out_valid}, 32'd1);
      check("hold_data", out_data, 32'h000000AA);
      flush  = 1'b1;
      in_imm = 16'h00BB;
      in_tag = 5'd8;
      check("flush_in_ready", {31'd0, in_ready}, 32'd0);
      step();
      flush    = 1'b0;
      in_valid = 1'b0;
      check("flush_valid", {31'd0, out_valid}, 32'd0);
      step();
      check("flush_not_accepted", {31'd0, out_valid}, 32'd0);

      // Flush together with reset
      in_valid = 1'b1;
      in_imm   = 16'h00CC;
      step();
      check("preload_valid", {31'd0, out_valid}, 32'd1);
      flush = 1'b1;
      reset = 1'b1;
      step();
      check("flushreset_valid", {31'd0, out_valid}, 32'd0);
      check("flushreset_data", out_data, 32'd0);
      check("flushreset_tag", {27'd0, out_tag}, 32'd0);
      flush    = 1'b0;
      reset    = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      step();
      step();
      check("scoreboard_empty", exp_q.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_imm_extend_stage

// File: doc/imm_extend_stage.md
Name: imm_extend_stage

Overview:
Parametrised, registered immediate-generation stage for the MIPS ID→EX path. It generalises plain 16→32 sign extension to configurable input and output widths and four extension modes: sign, zero, upper (LUI) and branch-offset. The stage holds one pipeline register with valid/ready handshake, stall back-pressure and flush. A side-band tag (destination register) travels alongside the result.

Parameters:
IN_W, 16, immediate field width; must be ≥ 2
OUT_W, 32, extended result width; must be ≥ IN_W+2 (elaboration-time check, error otherwise)
TAG_W, 5, side-band tag width, passed through unmodified

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  input beat present
in_ready  out  1  stage can accept a beat this cycle
in_imm  in  IN_W  raw immediate field
in_mode  in  2  extension mode, see Behaviour
in_tag  in  TAG_W  side-band tag
flush  in  1  discard held and incoming beat
out_valid  out  1  out_data/out_tag hold a valid result
out_ready  in  1  consumer accepts the beat
out_data  out  OUT_W  extended immediate
out_tag  out  TAG_W  tag captured with out_data

Behaviour:
- One clock domain. Reset is synchronous and active-high: on a rising clk edge with reset=1, out_valid=0, out_data=0 and out_tag=0. Reset overrides flush and any handshake in the same cycle.
- Mode encoding, with E = OUT_W−IN_W:
  - 2'b00 SIGN: {E{imm[IN_W-1]}, imm}
  - 2'b01 ZERO: {E'b0, imm}
  - 2'b10 UPPER: {imm, E'b0}. When E < IN_W, only the low OUT_W bits of that concatenation are kept.
  - 2'b11 BRANCH: (SIGN result) << 2, low OUT_W bits kept, bits [1:0] = 0.
- Extension is computed combinationally from in_imm/in_mode and captured in the register at load. Latency is exactly 1 cycle from an accepted input to out_valid.
- in_ready = !flush && (!out_valid || out_ready). This is combinational and gives full throughput of 1 beat per cycle.
- Load (accept) happens when in_valid && in_ready. Next cycle: out_valid=1, and out_data/out_tag are updated.
- Drain happens when out_valid && out_ready && no load. Next cycle: out_valid=0, and out_data/out_tag hold their last values.
- Stall (out_valid && !out_ready): in_ready=0, and out_data/out_tag stay stable until accepted.
- Simultaneous drain and load: the new beat replaces the old one with no bubble.
- Flush has priority over load. Next cycle: out_valid=0, and the input beat of that cycle is not accepted (in_ready=0). out_data/out_tag may hold stale values.
- in_valid while !in_ready: the beat is not consumed. The producer must hold in_imm/in_mode/in_tag stable until it is accepted.
- out_data/out_tag change only on a load or on reset.

Decomposition:
- Package imm_ext_pkg holds the mode localparams (IMM_SIGN=2'b00, IMM_ZERO=2'b01, IMM_UPPER=2'b10, IMM_BRANCH=2'b11) and the 2-bit mode type.
- Sub-module imm_ext_core is the pure combinational IN_W→OUT_W extender for all four modes. It is reused by later decode logic.
- imm_extend_stage wraps imm_ext_core and adds the register and handshake.

Test Plan:
- Reset: assert reset for 2 cycles with in_valid=1 → out_valid=0, out_data=0, out_tag=0. First accepted beat after reset appears one cycle later.
- Modes (IN_W=16, OUT_W=32), imm=0x8001, tag=5'd9:
  - SIGN → 0xFFFF8001
  - ZERO → 0x00008001
  - UPPER → 0x80010000
  - all with out_tag=9
- BRANCH: imm=0xFFFF → 0xFFFFFFFC; imm=0x7FFF → 0x0001FFFC.
- Back-pressure: load 0x0010, then hold out_ready=0 for 3 cycles → in_ready=0 and out_data stays 0x00000010. Raising out_ready with the next beat 0x0020 pending → 0x00000020 appears the next cycle, with no bubble.
- Streaming: 8 back-to-back beats with out_ready=1 → 8 results on consecutive cycles, in order, out_valid continuously 1.
- Flush: held beat, flush=1 with in_valid=1 → next cycle out_valid=0 and the input beat is not accepted. Flush together with reset → reset values.
